// File: rtl/expr_vec_pkg.sv
// Shared types and constants for the expression-unit vector driver:
// FSM states, MISR polynomial, LFSR taps and operand field layout.
package expr_vec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

    // x^64 + x^63 + x^61 + x^60 + 1, expressed as zero-based bit positions
    localparam int LFSR_TAP0 = 63;
    localparam int LFSR_TAP1 = 62;
    localparam int LFSR_TAP2 = 60;
    localparam int LFSR_TAP3 = 59;

    localparam int A0_OFF = 0;   localparam int A0_W = 4;
    localparam int A1_OFF = 4;   localparam int A1_W = 5;
    localparam int A2_OFF = 9;   localparam int A2_W = 6;
    localparam int A3_OFF = 15;  localparam int A3_W = 4;
    localparam int A4_OFF = 19;  localparam int A4_W = 5;
    localparam int A5_OFF = 24;  localparam int A5_W = 6;
    localparam int B0_OFF = 30;  localparam int B0_W = 4;
    localparam int B1_OFF = 34;  localparam int B1_W = 5;
    localparam int B2_OFF = 39;  localparam int B2_W = 6;
    localparam int B3_OFF = 45;  localparam int B3_W = 4;
    localparam int B4_OFF = 49;  localparam int B4_W = 5;
    localparam int B5_OFF = 54;  localparam int B5_W = 6;

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return {s[62:0], s[LFSR_TAP0] ^ s[LFSR_TAP1] ^ s[LFSR_TAP2] ^ s[LFSR_TAP3]};
    endfunction

endpackage

// File: rtl/expr_vec_misr.sv
// 32-bit signature register: folds the 90-bit response to 32 bits and
// accumulates it with a CRC-32 style shift.
module expr_vec_misr
    import expr_vec_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [89:0] y,
    output logic [31:0] sig
);

    logic [31:0] fold;
    logic [31:0] sig_next;

    always_comb begin
        fold     = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
        sig_next = {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ fold;
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            sig <= 32'h0;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/expr_vec_driver.sv
// Pseudo-random operand driver for an expression unit: LFSR-sourced operands,
// settle/capture sequencing and response signature. Optional golden compare
// port pair is enabled by EXPR_VEC_DRIVER_GOLDEN_EN.
module expr_vec_driver
    import expr_vec_pkg::*;
#(
    parameter int          NUM_VECTORS   = 256,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [63:0] SEED          = 64'h1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [3:0]        a0,
    output logic [4:0]        a1,
    output logic [5:0]        a2,
    output logic signed [3:0] a3,
    output logic signed [4:0] a4,
    output logic signed [5:0] a5,
    output logic [3:0]        b0,
    output logic [4:0]        b1,
    output logic [5:0]        b2,
    output logic signed [3:0] b3,
    output logic signed [4:0] b4,
    output logic signed [5:0] b5,
    input  logic [89:0]       y,
`ifdef EXPR_VEC_DRIVER_GOLDEN_EN
    input  logic [31:0]       golden_sig,
    output logic              pass,
`endif
    output logic              busy,
    output logic              done,
    output logic [31:0]       sig
);

    localparam logic [63:0] SEED_EFF    = (SEED == 64'h0) ? 64'h1 : SEED;
    localparam logic [15:0] LAST_VEC    = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [63:0] lfsr;
    logic [15:0] vec_cnt;
    logic [3:0]  settle_cnt;
    logic        load;
    logic        capture;

    // start is a level sampled only in IDLE/DONE; it is ignored while busy
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_DRIVE;
            ST_DRIVE:   if (settle_cnt == SETTLE_LAST) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = (vec_cnt != LAST_VEC) ? ST_DRIVE : ST_DONE;
            ST_DONE:    if (start) state_next = ST_DRIVE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        capture = 1'b0;
        case (state)
            ST_IDLE:    load = start;
            ST_DRIVE:   busy = 1'b1;
            ST_CAPTURE: begin
                busy    = 1'b1;
                capture = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                load = start;
            end
            default: ;
        endcase
    end

    // LFSR moves only on the capture edge, so operands hold through DRIVE and CAPTURE
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr       <= 64'h0;
            vec_cnt    <= 16'h0;
            settle_cnt <= 4'h0;
        end else if (load) begin
            lfsr       <= SEED_EFF;
            vec_cnt    <= 16'h0;
            settle_cnt <= 4'h0;
        end else if (capture) begin
            lfsr       <= lfsr_step(lfsr);
            vec_cnt    <= vec_cnt + 16'd1;
            settle_cnt <= 4'h0;
        end else if (state == ST_DRIVE) begin
            settle_cnt <= settle_cnt + 4'd1;
        end
    end

    expr_vec_misr u_misr (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (capture),
        .y     (y),
        .sig   (sig)
    );

    assign a0 = lfsr[A0_OFF +: A0_W];
    assign a1 = lfsr[A1_OFF +: A1_W];
    assign a2 = lfsr[A2_OFF +: A2_W];
    assign a3 = lfsr[A3_OFF +: A3_W];
    assign a4 = lfsr[A4_OFF +: A4_W];
    assign a5 = lfsr[A5_OFF +: A5_W];
    assign b0 = lfsr[B0_OFF +: B0_W];
    assign b1 = lfsr[B1_OFF +: B1_W];
    assign b2 = lfsr[B2_OFF +: B2_W];
    assign b3 = lfsr[B3_OFF +: B3_W];
    assign b4 = lfsr[B4_OFF +: B4_W];
    assign b5 = lfsr[B5_OFF +: B5_W];

`ifdef EXPR_VEC_DRIVER_GOLDEN_EN
    assign pass = (state == ST_DONE) && (sig == golden_sig);
`endif

endmodule

// File: tb/tb_expr_vec_driver.sv
// Bench for expr_vec_driver: three instances (main run model, minimal run with
// all-ones response, zero seed) checked against a run-level model and literals.
module tb_expr_vec_driver;

    localparam int NB = 4;
    localparam int SB = 1;
    localparam int PB = SB + 2;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   y_mode = 0;

    logic [3:0] a0_a, a3_a, b0_a, b3_a, a0_b, a3_b, b0_b, b3_b, a0_c, a3_c, b0_c, b3_c;
    logic [4:0] a1_a, a4_a, b1_a, b4_a, a1_b, a4_b, b1_b, b4_b, a1_c, a4_c, b1_c, b4_c;
    logic [5:0] a2_a, a5_a, b2_a, b5_a, a2_b, a5_b, b2_b, b5_b, a2_c, a5_c, b2_c, b5_c;
    logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
    logic [31:0] sig_a, sig_b, sig_c;
    logic [89:0] y_a = '1;
    logic [89:0] y_c = '0;
    logic [89:0] y_b;
    logic [31:0] golden_a = 32'h0;
    logic        pass_a;

    wire [59:0] ops_a = {b5_a, b4_a, b3_a, b2_a, b1_a, b0_a, a5_a, a4_a, a3_a, a2_a, a1_a, a0_a};
    wire [59:0] ops_b = {b5_b, b4_b, b3_b, b2_b, b1_b, b0_b, a5_b, a4_b, a3_b, a2_b, a1_b, a0_b};

    // stand-in expression unit: response derived from the presented operands
    function automatic logic [89:0] yfun(input logic [59:0] x, input int mode);
        if (mode == 0) return 90'h0;
        return {x[59:30] ^ x[29:0], x};
    endfunction

    always_comb y_b = yfun(ops_b, y_mode);

    expr_vec_driver #(.NUM_VECTORS(1), .SETTLE_CYCLES(0), .SEED(64'h1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .a0(a0_a), .a1(a1_a), .a2(a2_a), .a3(a3_a), .a4(a4_a), .a5(a5_a),
        .b0(b0_a), .b1(b1_a), .b2(b2_a), .b3(b3_a), .b4(b4_a), .b5(b5_a),
        .y(y_a),
`ifdef EXPR_VEC_DRIVER_GOLDEN_EN
        .golden_sig(golden_a), .pass(pass_a),
`endif
        .busy(busy_a), .done(done_a), .sig(sig_a)
    );

    expr_vec_driver #(.NUM_VECTORS(NB), .SETTLE_CYCLES(SB), .SEED(64'h1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .a0(a0_b), .a1(a1_b), .a2(a2_b), .a3(a3_b), .a4(a4_b), .a5(a5_b),
        .b0(b0_b), .b1(b1_b), .b2(b2_b), .b3(b3_b), .b4(b4_b), .b5(b5_b),
        .y(y_b), .busy(busy_b), .done(done_b), .sig(sig_b)
    );

    expr_vec_driver #(.NUM_VECTORS(1), .SETTLE_CYCLES(2), .SEED(64'h0)) dut_c (
        .clk(clk), .reset(reset), .start(start_c),
        .a0(a0_c), .a1(a1_c), .a2(a2_c), .a3(a3_c), .a4(a4_c), .a5(a5_c),
        .b0(b0_c), .b1(b1_c), .b2(b2_c), .b3(b3_c), .b4(b4_c), .b5(b5_c),
        .y(y_c), .busy(busy_c), .done(done_c), .sig(sig_c)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // run-level model of dut_b: per-vector LFSR states and signatures
    logic [63:0] m_l [0:NB];
    logic [31:0] m_s [0:NB];
    logic [31:0] exp_q [$];
    bit          m_run = 1'b0;
    bit          m_fin = 1'b0;
    int          m_n = 0;

    function automatic logic [63:0] ref_lfsr(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [89:0] y);
        logic [31:0] f;
        f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
        return (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    endfunction

    task automatic build_run();
        m_l[0] = 64'h1;
        m_s[0] = 32'h0;
        for (int i = 0; i < NB; i++) begin
            m_s[i+1] = ref_misr(m_s[i], yfun(m_l[i][59:0], y_mode));
            m_l[i+1] = ref_lfsr(m_l[i]);
        end
        exp_q.push_back(m_s[NB]);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_run = 1'b0;
            m_n   = 0;
            m_fin = 1'b0;
            exp_q.delete();
        end else if (m_run && m_n < NB * PB) begin
            m_n++;
            if (m_n == NB * PB) m_fin = 1'b1;
        end else if (start_b) begin
            m_run = 1'b1;
            m_n   = 0;
            build_run();
        end
    end

    // scoreboard: dut_b against the model on every cycle
    initial forever begin
        int c;
        logic [63:0] e_l;
        logic [31:0] e_s;
        @(negedge clk);
        c = m_n / PB;
        if (c > NB) c = NB;
        e_l = m_run ? m_l[c] : 64'h0;
        e_s = m_run ? m_s[c] : 32'h0;
        check("ops_b", 64'(ops_b), 64'(e_l[59:0]));
        check("sig_b", 64'(sig_b), 64'(e_s));
        check("busy_b", 64'(busy_b), 64'(m_run && m_n < NB * PB));
        check("done_b", 64'(done_b), 64'(m_run && m_n >= NB * PB));
        if (m_fin) begin
            m_fin = 1'b0;
            if (exp_q.size() == 0) check("final_sig_queue", 64'(exp_q.size()), 64'd1);
            else check("final_sig_b", 64'(sig_b), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_b();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
    endtask

    task automatic wait_done_b();
        for (int i = 0; i < 200 && !done_b; i++) tick();
        check("done_b_timeout", 64'(done_b), 64'd1);
    endtask

    initial begin
        int k;
        logic [31:0] ref_sig;

        // reset then idle
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        check("idle_ops_b", 64'(ops_b), 64'd0);
        check("idle_ops_a", 64'(ops_a), 64'd0);
        check("idle_busy_b", 64'(busy_b), 64'd0);
        check("idle_done_b", 64'(done_b), 64'd0);
        check("idle_sig_b", 64'(sig_b), 64'd0);

        // first run with operand-dependent response
        y_mode = 1;
        pulse_b();
        check("first_a0", 64'(a0_b), 64'd1);
        check("first_rest", 64'(ops_b[59:4]), 64'd0);
        repeat (PB) tick();
        check("second_a0", 64'(a0_b), 64'd2);
        wait_done_b();
        check("final_ops_b", 64'(ops_b), 64'h10);
        ref_sig = m_s[NB];
        repeat (3) tick();
        check("hold_ops_b", 64'(ops_b), 64'h10);

        // zero response, start pulses while busy, exact done edge
        y_mode = 0;
        k = cyc;
        pulse_b();
        repeat (2) tick();
        pulse_b();
        repeat (3) tick();
        pulse_b();
        for (int i = 0; i < 50 && cyc < k + NB * PB; i++) tick();
        check("done_early", 64'(done_b), 64'd0);
        tick();
        check("done_edge", 64'(cyc), 64'(k + 1 + NB * PB));
        check("done_on_time", 64'(done_b), 64'd1);
        check("zero_sig", 64'(sig_b), 64'd0);

        // reset during the third DRIVE, then a clean rerun
        y_mode = 1;
        pulse_b();
        repeat (2 * PB) tick();
        check("abort_busy", 64'(busy_b), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_sig", 64'(sig_b), 64'd0);
        check("abort_busy_low", 64'(busy_b), 64'd0);
        pulse_b();
        wait_done_b();
        check("rerun_sig", 64'(sig_b), 64'(ref_sig));

        // single vector, no settle, all-ones response
        k = cyc;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("a_done_k1", 64'(done_a), 64'd0);
        tick();
        check("a_done_k2", 64'(done_a), 64'd0);
        tick();
        check("a_done_k3", 64'(done_a), 64'd1);
        check("a_edge", 64'(cyc), 64'(k + 3));
        check("a_sig", 64'(sig_a), 64'h03FFFFFF);
`ifdef EXPR_VEC_DRIVER_GOLDEN_EN
        golden_a = 32'h03FFFFFF;
        #1;
        check("pass_match", 64'(pass_a), 64'd1);
        golden_a = 32'h0;
        #1;
        check("pass_mismatch", 64'(pass_a), 64'd0);
`endif

        // zero seed replaced by one
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        check("zero_seed_a0", 64'(a0_c), 64'd1);
        check("zero_seed_busy", 64'(busy_c), 64'd1);

        repeat (2) tick();
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
